// File: rtl/mac_operand_feeder_pkg.sv
// Shared constants, state encoding and field offsets for the MAC operand path.
// The MAC reuses the lane/bias offsets to unpack the same coefficient word.
package mac_operand_feeder_pkg;

    localparam int LANE_W          = 8;
    localparam int BIAS_W          = 10;
    localparam int NUM_LANES       = 3;
    localparam int OP_W            = 10;
    localparam int BIAS_LSB        = 0;
    localparam int COEFF_LANE_BASE = BIAS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } feeder_state_e;

    // Lane 0 sits in the most significant byte of the packed lane field.
    function automatic int lane_lsb(input int k);
        return (NUM_LANES - 1 - k) * LANE_W;
    endfunction

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Request, RAM1 read port and operand stream of the MAC operand feeder.
// master is the feeder's view; slave is the traversal/RAM/MAC side.
interface mac_operand_feeder_if
    import mac_operand_feeder_pkg::*;
#(
    parameter int ATTR_WIDTH      = 24,
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM1_ADDR_WIDTH = 8
);
    logic                       req_valid;
    logic                       req_ready;
    logic [RAM1_ADDR_WIDTH-1:0] req_addr;
    logic [ATTR_WIDTH-1:0]      req_attr;

    logic                       ram1_rd_en;
    logic [RAM1_ADDR_WIDTH-1:0] ram1_rd_addr;
    logic [RAM1_DATA_WIDTH-1:0] ram1_rd_data;

    logic                       op_valid;
    logic                       op_ready;
    logic [OP_W-1:0]            op_a;
    logic [OP_W-1:0]            op_b;
    logic                       op_first;
    logic                       op_last;

    logic                       busy;

    modport master (
        input  req_valid, req_addr, req_attr, ram1_rd_data, op_ready,
        output req_ready, ram1_rd_en, ram1_rd_addr,
               op_valid, op_a, op_b, op_first, op_last, busy
    );

    modport slave (
        output req_valid, req_addr, req_attr, ram1_rd_data, op_ready,
        input  req_ready, ram1_rd_en, ram1_rd_addr,
               op_valid, op_a, op_b, op_first, op_last, busy
    );

endinterface

// File: rtl/mac_operand_feeder.sv
// Fetches one coefficient word per request and serialises it as three
// attribute x weight lane beats followed by a bias beat, with backpressure.
module mac_operand_feeder
    import mac_operand_feeder_pkg::*;
#(
    parameter int ATTR_WIDTH      = 24,
    parameter int RAM1_DATA_WIDTH = 34,
    parameter int RAM1_ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mac_operand_feeder_if.master   bus
);

    if ((RAM1_DATA_WIDTH != ATTR_WIDTH + BIAS_W) || (ATTR_WIDTH != NUM_LANES * LANE_W)) begin : g_width_check
        $error("mac_operand_feeder: coefficient/attribute widths are inconsistent");
    end

    feeder_state_e              r_state;
    feeder_state_e              w_state_next;
    logic [1:0]                 r_k;
    logic [1:0]                 w_k_next;
    logic [ATTR_WIDTH-1:0]      r_attr;
    logic [RAM1_DATA_WIDTH-1:0] r_coeff;
    logic [RAM1_DATA_WIDTH-1:0] w_coeff_src;
    logic                       r_req_ready;
    logic [RAM1_ADDR_WIDTH-1:0] r_rd_addr;

    logic                       r_op_valid;
    logic                       r_op_first;
    logic                       r_op_last;
    logic [OP_W-1:0]            r_op_a;
    logic [OP_W-1:0]            r_op_b;
    logic                       w_op_valid_next;
    logic                       w_op_first_next;
    logic                       w_op_last_next;
    logic [OP_W-1:0]            w_op_a_next;
    logic [OP_W-1:0]            w_op_b_next;

    logic                       w_accept;
    logic                       w_beat_done;
    logic [LANE_W-1:0]          w_attr_lanes [NUM_LANES];
    logic [LANE_W-1:0]          w_wt_lanes   [NUM_LANES];

    assign w_accept    = (r_state == IDLE) && r_req_ready && bus.req_valid;
    assign w_beat_done = r_op_valid && bus.op_ready;

    // In FETCH the RAM word is consumed directly so beat 0 is ready one edge later.
    assign w_coeff_src = (r_state == FETCH) ? bus.ram1_rd_data : r_coeff;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lanes
        assign w_attr_lanes[gi] = r_attr[lane_lsb(gi) +: LANE_W];
        assign w_wt_lanes[gi]   = w_coeff_src[COEFF_LANE_BASE + lane_lsb(gi) +: LANE_W];
    end

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_state_next = EMIT;
                w_k_next     = 2'd0;
            end
            EMIT: begin
                if (w_beat_done) begin
                    if (r_k == 2'd3) begin
                        w_state_next = IDLE;
                    end else begin
                        w_k_next = r_k + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Next beat is a pure function of next state/k, so a stalled beat re-registers unchanged.
    always_comb begin
        w_op_valid_next = (w_state_next == EMIT);
        w_op_first_next = w_op_valid_next && (w_k_next == 2'd0);
        w_op_last_next  = w_op_valid_next && (w_k_next == 2'd3);
        w_op_a_next     = '0;
        w_op_b_next     = '0;
        if (w_op_valid_next) begin
            case (w_k_next)
                2'd0: begin
                    w_op_a_next = OP_W'(w_attr_lanes[0]);
                    w_op_b_next = OP_W'(w_wt_lanes[0]);
                end
                2'd1: begin
                    w_op_a_next = OP_W'(w_attr_lanes[1]);
                    w_op_b_next = OP_W'(w_wt_lanes[1]);
                end
                2'd2: begin
                    w_op_a_next = OP_W'(w_attr_lanes[2]);
                    w_op_b_next = OP_W'(w_wt_lanes[2]);
                end
                default: begin
                    w_op_a_next = OP_W'(1);
                    w_op_b_next = OP_W'(w_coeff_src[BIAS_LSB +: BIAS_W]);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_attr      <= '0;
            r_coeff     <= '0;
            r_req_ready <= 1'b0;
            r_rd_addr   <= '0;
            r_op_valid  <= 1'b0;
            r_op_first  <= 1'b0;
            r_op_last   <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_k         <= w_k_next;
            r_req_ready <= (w_state_next == IDLE);
            r_op_valid  <= w_op_valid_next;
            r_op_first  <= w_op_first_next;
            r_op_last   <= w_op_last_next;
            r_op_a      <= w_op_a_next;
            r_op_b      <= w_op_b_next;
            if (w_accept) begin
                r_attr    <= bus.req_attr;
                r_rd_addr <= bus.req_addr;
            end
            if (r_state == FETCH) begin
                r_coeff <= bus.ram1_rd_data;
            end
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.ram1_rd_en   = w_accept;
    assign bus.ram1_rd_addr = w_accept ? bus.req_addr : r_rd_addr;
    assign bus.op_valid     = r_op_valid;
    assign bus.op_first     = r_op_first;
    assign bus.op_last      = r_op_last;
    assign bus.op_a         = r_op_a;
    assign bus.op_b         = r_op_b;
    assign bus.busy         = (r_state != IDLE);

endmodule
